// File: rtl/maxpool_pkg.sv
// Shared constants for the 2x2 max-pool window buffer: default feature-map size,
// counter width helper and window pixel positions.
package maxpool_pkg;

    localparam int DEF_IMG_W = 24;
    localparam int DEF_IMG_H = 24;

    // Counter width for a dimension of n positions, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_COL_W = cnt_w(DEF_IMG_W);
    localparam int DEF_ROW_W = cnt_w(DEF_IMG_H);

    // Bit positions of the window pixels inside a packed 4-bit window.
    localparam logic [1:0] WIN_TL = 2'd0;
    localparam logic [1:0] WIN_TR = 2'd1;
    localparam logic [1:0] WIN_BL = 2'd2;
    localparam logic [1:0] WIN_BR = 2'd3;

endpackage

// File: rtl/maxpool_line_buf.sv
// One-row, 1-bit line buffer: single write port plus combinational reads of the
// addressed column and its left neighbour.
module maxpool_line_buf
    import maxpool_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int COL_W = cnt_w(IMG_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  logic             wr_bit,
    input  logic [COL_W-1:0] rd_col,
    output logic             rd_left,
    output logic             rd_right
);

    logic [IMG_W-1:0] row_q;
    logic [COL_W-1:0] left_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
        end else if (wr_en) begin
            row_q[wr_col] <= wr_bit;
        end
    end

    // Column 0 has no left neighbour; clamp so the address never wraps.
    always_comb begin
        left_col = (rd_col == '0) ? '0 : rd_col - COL_W'(1);
        rd_left  = row_q[left_col];
        rd_right = row_q[rd_col];
    end

endmodule

// File: rtl/maxpool_window_buf.sv
// Raster-order binary pixel stream to non-overlapping 2x2 stride-2 windows.
// Optional start-of-frame resync input enabled by MAXPOOL_SOF_SYNC_EN.
module maxpool_window_buf
    import maxpool_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    input  logic pixel_in,
`ifdef MAXPOOL_SOF_SYNC_EN
    input  logic sof_in,
`endif
    output logic valid_out_buf,
    output logic pixel_0,
    output logic pixel_1,
    output logic pixel_2,
    output logic pixel_3,
    output logic frame_done
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_cnt;
    logic [COL_W-1:0] col_cur;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_cnt;
    logic [ROW_W-1:0] row_cur;
    logic [ROW_W-1:0] row_nxt;

    logic sof_acc;
    logic col_last;
    logic row_last;
    logic buf_wr;
    logic left_wr;
    logic win_hit;
    logic last_pix;
    logic left_reg;
    logic buf_left;
    logic buf_right;

    logic [3:0] win_p1;
    logic       vld_p1;
    logic       done_p1;

    // A pixel carrying start-of-frame is forced to position (0,0).
    always_comb begin
`ifdef MAXPOOL_SOF_SYNC_EN
        sof_acc = valid_in & sof_in;
`else
        sof_acc = 1'b0;
`endif
        col_cur  = sof_acc ? '0 : col_cnt;
        row_cur  = sof_acc ? '0 : row_cnt;
        col_last = (col_cur == COL_LAST);
        row_last = (row_cur == ROW_LAST);
        col_nxt  = col_last ? '0 : col_cur + COL_W'(1);
        if (col_last) begin
            row_nxt = row_last ? '0 : row_cur + ROW_W'(1);
        end else begin
            row_nxt = row_cur;
        end
        // Odd dimensions fall out naturally: the trailing column/row has an even index.
        buf_wr   = valid_in & ~row_cur[0];
        left_wr  = valid_in &  row_cur[0] & ~col_cur[0];
        win_hit  = valid_in &  row_cur[0] &  col_cur[0];
        last_pix = valid_in &  col_last   &  row_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (valid_in) begin
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_reg <= 1'b0;
        end else if (sof_acc) begin
            left_reg <= 1'b0;
        end else if (left_wr) begin
            left_reg <= pixel_in;
        end
    end

    maxpool_line_buf #(
        .IMG_W (IMG_W),
        .COL_W (COL_W)
    ) u_line_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (buf_wr),
        .wr_col   (col_cur),
        .wr_bit   (pixel_in),
        .rd_col   (col_cur),
        .rd_left  (buf_left),
        .rd_right (buf_right)
    );

    // Stage p1: registered window, strobe and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_p1  <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= win_hit;
            done_p1 <= last_pix;
            if (win_hit) begin
                win_p1[WIN_TL] <= buf_left;
                win_p1[WIN_TR] <= buf_right;
                win_p1[WIN_BL] <= left_reg;
                win_p1[WIN_BR] <= pixel_in;
            end
        end
    end

    assign valid_out_buf = vld_p1;
    assign pixel_0       = win_p1[WIN_TL];
    assign pixel_1       = win_p1[WIN_TR];
    assign pixel_2       = win_p1[WIN_BL];
    assign pixel_3       = win_p1[WIN_BR];
    assign frame_done    = done_p1;

endmodule

// File: tb/tb_maxpool_window_buf.sv
// Bench for maxpool_window_buf: a 4x4 and a 5x5 instance driven by directed and
// random frames, compared against a 2-D image reference model.
module tb_maxpool_window_buf;

    logic clk = 1'b0;
    logic rst;
    logic v4, p4, s4, vo4, a4, b4, c4, d4, fd4;
    logic v5, p5, s5, vo5, a5, b5, c5, d5, fd5;

    int checks = 0;
    int errors = 0;

    int       pos[2];
    logic     img[2][5][5];
    logic [3:0] ewin[2];
    int       nwin[2];
    int       nfd[2];

    always #5 clk = ~clk;

    maxpool_window_buf #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (v4),
        .pixel_in      (p4),
`ifdef MAXPOOL_SOF_SYNC_EN
        .sof_in        (s4),
`endif
        .valid_out_buf (vo4),
        .pixel_0       (a4),
        .pixel_1       (b4),
        .pixel_2       (c4),
        .pixel_3       (d4),
        .frame_done    (fd4)
    );

    maxpool_window_buf #(.IMG_W(5), .IMG_H(5)) dut5 (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (v5),
        .pixel_in      (p5),
`ifdef MAXPOOL_SOF_SYNC_EN
        .sof_in        (s5),
`endif
        .valid_out_buf (vo5),
        .pixel_0       (a5),
        .pixel_1       (b5),
        .pixel_2       (c5),
        .pixel_3       (d5),
        .frame_done    (fd5)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pos[d]  = 0;
            ewin[d] = 4'b0;
        end
    endtask

    // One clock on instance d (0: 4x4, 1: 5x5); checks outputs on the falling edge after.
    task automatic step(input int d, input logic v, input logic p, input logic s);
        int w, r, c;
        logic ev, ef;
        logic [3:0] gw;
        logic gv, gf;
        w  = (d == 1) ? 5 : 4;
        ev = 1'b0;
        ef = 1'b0;
        if (d == 0) begin v4 = v; p4 = p; s4 = s; end
        else        begin v5 = v; p5 = p; s5 = s; end
        if (v) begin
            if (s) pos[d] = 0;
            r = pos[d] / w;
            c = pos[d] % w;
            img[d][r][c] = p;
            if (r % 2 == 1 && c % 2 == 1 && r < 2 * (w / 2) && c < 2 * (w / 2)) begin
                ev = 1'b1;
                ewin[d] = {img[d][r][c], img[d][r][c-1], img[d][r-1][c], img[d][r-1][c-1]};
            end
            ef = (pos[d] == w * w - 1);
            pos[d] = (pos[d] + 1) % (w * w);
        end
        @(posedge clk);
        @(negedge clk);
        if (d == 0) begin v4 = 1'b0; s4 = 1'b0; end
        else        begin v5 = 1'b0; s5 = 1'b0; end
        gv = (d == 1) ? vo5 : vo4;
        gf = (d == 1) ? fd5 : fd4;
        gw = (d == 1) ? {d5, c5, b5, a5} : {d4, c4, b4, a4};
        if (gv) nwin[d]++;
        if (gf) nfd[d]++;
        check_eq($sformatf("vld%0d", d), 32'(gv), 32'(ev));
        check_eq($sformatf("win%0d", d), 32'(gw), 32'(ewin[d]));
        check_eq($sformatf("done%0d", d), 32'(gf), 32'(ef));
    endtask

    task automatic clear_counts();
        nwin[0] = 0; nwin[1] = 0; nfd[0] = 0; nfd[1] = 0;
    endtask

    // Random frame with random valid gaps.
    task automatic rand_frame(input int d);
        int w, n;
        w = (d == 1) ? 5 : 4;
        n = 0;
        while (n < w * w) begin
            if ($urandom_range(0, 3) != 0) begin
                step(d, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                n++;
            end else begin
                step(d, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pat;
        v4 = 0; p4 = 0; s4 = 0; v5 = 0; p5 = 0; s5 = 0;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    img[d][r][c] = 1'b0;
        model_reset();
        clear_counts();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_vld", 32'(vo4), 32'd0);
        check_eq("rst_win", 32'({d4, c4, b4, a4}), 32'd0);
        check_eq("rst_done", 32'(fd4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Partial frame then asynchronous reset.
        for (int i = 0; i < 6; i++) step(0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_eq("mid_rst_vld", 32'(vo4), 32'd0);
        check_eq("mid_rst_win", 32'({d4, c4, b4, a4}), 32'd0);
        check_eq("mid_rst_done", 32'(fd4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();

        // Directed frame 1000/0000/0000/0001.
        pat = 16'h8001;
        for (int i = 0; i < 16; i++) step(0, 1'b1, pat[i], 1'b0);
        check_eq("dir_nwin", 32'(nwin[0]), 32'd4);
        check_eq("dir_nfd", 32'(nfd[0]), 32'd1);

        // Same frame with valid alternating.
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, pat[i], 1'b0);
            step(0, 1'b0, 1'b1, 1'b0);
        end
        check_eq("alt_nwin", 32'(nwin[0]), 32'd4);
        check_eq("alt_nfd", 32'(nfd[0]), 32'd1);

        // Back-to-back all-ones then all-zeros.
        clear_counts();
        for (int i = 0; i < 32; i++) step(0, 1'b1, (i < 16), 1'b0);
        check_eq("b2b_nwin", 32'(nwin[0]), 32'd8);
        check_eq("b2b_nfd", 32'(nfd[0]), 32'd2);

        // 5x5 all ones.
        clear_counts();
        for (int i = 0; i < 25; i++) step(1, 1'b1, 1'b1, 1'b0);
        check_eq("odd_nwin", 32'(nwin[1]), 32'd4);
        check_eq("odd_nfd", 32'(nfd[1]), 32'd1);

        // Random frames on both instances.
        for (int k = 0; k < 4; k++) begin
            clear_counts();
            rand_frame(0);
            rand_frame(1);
            check_eq("rnd_nwin4", 32'(nwin[0]), 32'd4);
            check_eq("rnd_nwin5", 32'(nwin[1]), 32'd4);
            check_eq("rnd_nfd", 32'(nfd[0] + nfd[1]), 32'd2);
        end

`ifdef MAXPOOL_SOF_SYNC_EN
        // Resync on the third accepted pixel.
        clear_counts();
        step(0, 1'b1, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'($urandom_range(0, 1)), (i == 0));
        check_eq("sof_nwin", 32'(nwin[0]), 32'd4);
        check_eq("sof_nfd", 32'(nfd[0]), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
